ramdrain: RTL

Reader side of the 160-sample capture buffer. Once the fill counter reports the buffer full, this block reads all DEPTH entries from the synchronous-read RAM in address order. It streams them to a downstream consumer, such as the display line builder or a decimator, over a valid/ready handshake with backpressure. Runs entirely in the clk_adc domain, alongside the fill logic.

---
 rtl/ramdrain.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ramdrain.sv
`default_nettype none
// ============================================================================
//  Module   : ramdrain
//  Purpose  : Reader side of the capture buffer. On start, reads all DEPTH
//             entries of a synchronous-read RAM in address order and streams
//             them out over a valid/ready handshake. A 2-entry skid FIFO
//             plus a credit rule keeps full throughput while tolerating
//             arbitrary backpressure.
//  Ports    : clk_adc   - clock, all logic on rising edge
//             reset     - synchronous, active-high
//             start     - drain request, honoured only in IDLE
//             rd_en     - RAM read strobe
//             rd_addr   - RAM read address
//             rd_data   - RAM read data, valid the cycle after rd_en
//             out_data  - sample at FIFO head (0 when empty)
//             out_valid - out_data valid
//             out_ready - consumer accept
//             out_last  - head sample came from address DEPTH-1
//             busy      - high while streaming
//             done      - one-cycle pulse after the last sample is accepted
//  Revision : 1.0 - initial release
// ============================================================================
module ramdrain #(
  parameter int DEPTH  = 160,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk_adc,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  c_depth_cnt = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  c_last_cnt  = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_accepted;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_done;

  // 2-entry skid FIFO: data plus a flag marking the sample from DEPTH-1
  logic [DATA_W-1:0] r_fifo_data [2];
  logic              r_fifo_last [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic              w_pop;
  logic              w_push;
  logic              w_credit;
  logic              w_start_drain;
  logic              w_final_pop;

  assign out_valid = (r_count != 2'd0);
  assign w_pop     = out_valid & out_ready;
  assign w_push    = r_inflight;

  // A read may issue only if, after this cycle's pop, the buffered plus
  // in-flight samples leave room in the 2-entry FIFO. The pop is added on
  // the right-hand side so the arithmetic never goes negative.
  assign w_credit = (({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

  assign rd_en    = (r_state == S_STREAM) && (r_issued < c_depth_cnt) && w_credit;
  assign rd_addr  = r_rd_addr;
  assign out_data = out_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign out_last = out_valid & r_fifo_last[r_rd_ptr];
  assign busy     = (r_state == S_STREAM);
  assign done     = r_done;

  // Next-state logic
  always_comb begin
    w_state_next  = r_state;
    w_start_drain = 1'b0;
    w_final_pop   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next  = S_STREAM;
          w_start_drain = 1'b1;
        end
      end
      S_STREAM: begin
        if (w_pop && (r_accepted == c_last_cnt)) begin
          w_state_next = S_IDLE;
          w_final_pop  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_final_pop;
    end
  end

  // Read issue and in-flight tracking; reset drops any outstanding read
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      r_issued        <= '0;
      r_rd_addr       <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else if (w_start_drain) begin
      r_issued        <= '0;
      r_rd_addr       <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= rd_en;
      r_inflight_last <= rd_en && (r_rd_addr == c_last_addr);
      if (rd_en) begin
        r_issued <= r_issued + CNT_W'(1);
        // Saturate at the final address rather than wrapping
        if (r_rd_addr != c_last_addr) begin
          r_rd_addr <= r_rd_addr + ADDR_W'(1);
        end
      end
    end
  end

  // Skid FIFO and accepted-sample counter
  always_ff @(posedge clk_adc) begin
    if (reset || w_start_drain) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last[0] <= 1'b0;
      r_fifo_last[1] <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= 2'd0;
      r_accepted     <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= rd_data;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr   <= ~r_rd_ptr;
        r_accepted <= r_accepted + CNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire
